leading_bit_counter: RTL and testbench

//  Multi-cycle normaliser for the MIPS ALU (CLZ/CLO); inverse job of the barrel shifter: given a word, find its shift amount.

---
 rtl/alu_pkg.sv | 17 +
 rtl/lbc_stage.sv | 30 +++
 rtl/leading_bit_counter.sv | 111 +++++++++++
 tb/tb_leading_bit_counter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: leading-bit counter FSM states and default search depth.
package alu_pkg;

  localparam int unsigned LBC_SHIFT_LAYERS = 5;

  typedef enum logic [1:0] {
    LBC_IDLE,
    LBC_SEARCH,
    LBC_DONE
  } lbc_state_t;

  // Width of the stage index register. The minimum of 1 keeps the index legal for SHIFT_LAYERS=1.
  function automatic int unsigned lbc_k_width(input int unsigned shift_layers);
    return (shift_layers > 1) ? $clog2(shift_layers) : 1;
  endfunction

endpackage

// File: rtl/lbc_stage.sv
// One binary-search stage of the leading-bit counter. Stage k tests the top 2**k bits of
// work. If they are all zero, the stage shifts work and norm left by 2**k.
module lbc_stage
  import alu_pkg::*;
#(
  parameter  int unsigned SHIFT_LAYERS = LBC_SHIFT_LAYERS,
  localparam int unsigned WIDTH        = 2**SHIFT_LAYERS,
  localparam int unsigned K_W          = lbc_k_width(SHIFT_LAYERS)
) (
  input  logic [WIDTH-1:0] work,
  input  logic [WIDTH-1:0] norm,
  input  logic [K_W-1:0]   k,
  output logic [WIDTH-1:0] work_nxt,
  output logic [WIDTH-1:0] norm_nxt,
  output logic             hit
);

  logic [SHIFT_LAYERS:0] step;
  logic [WIDTH-1:0]      mask;

  always_comb begin
    step     = {{SHIFT_LAYERS{1'b0}}, 1'b1} << k;
    // The mask selects the top 'step' bits. This avoids a variable-width part-select.
    mask     = ~({WIDTH{1'b1}} >> step);
    hit      = ~|(work & mask);
    work_nxt = hit ? (work << step) : work;
    norm_nxt = hit ? (norm << step) : norm;
  end

endmodule

// File: rtl/leading_bit_counter.sv
// Multi-cycle CLZ/CLO normaliser that performs one binary-search stage per clock behind a valid/ready handshake.
// When LEADING_BIT_EARLY_EXIT_EN is defined, the search stops as soon as the working word's MSB is set.
module leading_bit_counter
  import alu_pkg::*;
#(
  parameter  int unsigned SHIFT_LAYERS = LBC_SHIFT_LAYERS,
  localparam int unsigned WIDTH        = 2**SHIFT_LAYERS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  count_ones,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SHIFT_LAYERS:0] out_count,
  output logic [WIDTH-1:0]      out_norm,
  output logic                  out_zero
);

  localparam int unsigned K_W   = lbc_k_width(SHIFT_LAYERS);
  localparam int unsigned CNT_W = SHIFT_LAYERS + 1;

  lbc_state_t       state, state_nxt;
  logic [WIDTH-1:0] work, norm;
  logic [CNT_W-1:0] cnt;
  logic [K_W-1:0]   k;

  logic [WIDTH-1:0] work_nxt, norm_nxt, norm_fin;
  logic [CNT_W-1:0] step, cnt_upd, cnt_fin;
  logic             hit, last, fill, finish;

  lbc_stage #(
    .SHIFT_LAYERS(SHIFT_LAYERS)
  ) u_stage (
    .work    (work),
    .norm    (norm),
    .k       (k),
    .work_nxt(work_nxt),
    .norm_nxt(norm_nxt),
    .hit     (hit)
  );

  always_comb begin
    step    = CNT_W'(1) << k;
    last    = (k == '0);
    cnt_upd = cnt + (hit ? step : '0);
    // On the final stage, a still-clear MSB means the whole word was the target bit.
    // Add the one remaining position and clear the normalised word.
    fill     = last & ~work_nxt[WIDTH-1];
    cnt_fin  = cnt_upd + {{SHIFT_LAYERS{1'b0}}, fill};
    norm_fin = fill ? '0 : norm_nxt;
`ifdef LEADING_BIT_EARLY_EXIT_EN
    finish   = last | work_nxt[WIDTH-1];
`else
    finish   = last;
`endif
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LBC_IDLE:   if (in_valid)  state_nxt = LBC_SEARCH;
      LBC_SEARCH: if (finish)    state_nxt = LBC_DONE;
      LBC_DONE:   if (out_ready) state_nxt = LBC_IDLE;
      default:                   state_nxt = LBC_IDLE;
    endcase
  end

  assign in_ready  = rst_n & (state == LBC_IDLE);
  assign out_valid = (state == LBC_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LBC_IDLE;
      work      <= '0;
      norm      <= '0;
      cnt       <= '0;
      k         <= '0;
      out_count <= '0;
      out_norm  <= '0;
      out_zero  <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        LBC_IDLE: begin
          if (in_valid) begin
            work <= count_ones ? ~in_data : in_data;
            norm <= in_data;
            cnt  <= '0;
            k    <= K_W'(SHIFT_LAYERS - 1);
          end
        end
        LBC_SEARCH: begin
          work <= work_nxt;
          norm <= norm_fin;
          cnt  <= cnt_fin;
          k    <= k - 1'b1;
          if (finish) begin
            out_count <= cnt_fin;
            out_norm  <= norm_fin;
            out_zero  <= (cnt_fin == CNT_W'(WIDTH));
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_leading_bit_counter.sv
// Directed bench for leading_bit_counter (32-bit) with hand-computed counts, normalised words and latencies.
module tb_leading_bit_counter;

  localparam int unsigned SL = 5;
  localparam int unsigned W  = 32;
`ifdef LEADING_BIT_EARLY_EXIT_EN
  localparam int MSB_LAT = 1;
`else
  localparam int MSB_LAT = 5;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          count_ones = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [SL:0]   out_count;
  logic [W-1:0]  out_norm;
  logic          out_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  leading_bit_counter #(.SHIFT_LAYERS(SL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .count_ones(count_ones),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_norm  (out_norm),
    .out_zero  (out_zero)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for in_ready, then presents one request for exactly one accepting edge.
  task automatic start_op(input logic [W-1:0] d, input logic ones);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL start_op_ready: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    in_valid   = 1'b1;
    in_data    = d;
    count_ones = ones;
    tick();
    in_valid   = 1'b0;
  endtask

  // Returns the number of edges after the accept edge until out_valid is seen (capped at 20).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %0b, required 0", in_ready); end
    checks++; if (out_count !== '0) begin errors++; $display("FAIL reset_count: got %0d, required 0", out_count); end
    checks++; if (out_norm !== '0) begin errors++; $display("FAIL reset_norm: got %h, required 0", out_norm); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %0b, required 0", out_zero); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b, required 1", in_ready); end
  endtask

  task automatic test_clz_basic();
    int lat;
    start_op(32'h0001_0000, 1'b0);
    wait_done(lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL clz_basic_latency: got %0d, required 5", lat); end
    checks++; if (out_count !== 6'd15) begin errors++; $display("FAIL clz_basic_count: got %0d, required 15", out_count); end
    checks++; if (out_norm !== 32'h8000_0000) begin errors++; $display("FAIL clz_basic_norm: got %h, required 80000000", out_norm); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL clz_basic_zero: got %0b, required 0", out_zero); end
    handshake();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clz_basic_valid_drop: got %0b, required 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clz_basic_ready_back: got %0b, required 1", in_ready); end
    checks++; if (out_count !== 6'd15) begin errors++; $display("FAIL clz_basic_retain: got %0d, required 15", out_count); end
  endtask

  task automatic test_all_target();
    int lat;
    start_op(32'h0000_0000, 1'b0);
    wait_done(lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL clz_zero_latency: got %0d, required 5", lat); end
    checks++; if (out_count !== 6'd32) begin errors++; $display("FAIL clz_zero_count: got %0d, required 32", out_count); end
    checks++; if (out_norm !== 32'h0) begin errors++; $display("FAIL clz_zero_norm: got %h, required 0", out_norm); end
    checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL clz_zero_flag: got %0b, required 1", out_zero); end
    handshake();
    start_op(32'hFFFF_FFFF, 1'b1);
    wait_done(lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL clo_ones_latency: got %0d, required 5", lat); end
    checks++; if (out_count !== 6'd32) begin errors++; $display("FAIL clo_ones_count: got %0d, required 32", out_count); end
    checks++; if (out_norm !== 32'h0) begin errors++; $display("FAIL clo_ones_norm: got %h, required 0", out_norm); end
    checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL clo_ones_flag: got %0b, required 1", out_zero); end
    handshake();
  endtask

  task automatic test_clo();
    int lat;
    start_op(32'hFFF0_1234, 1'b1);
    wait_done(lat);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clo_done: out_valid=%0b, required 1", out_valid); end
    checks++; if (out_count !== 6'd12) begin errors++; $display("FAIL clo_count: got %0d, required 12", out_count); end
    checks++; if (out_norm !== 32'h0123_4000) begin errors++; $display("FAIL clo_norm: got %h, required 01234000", out_norm); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL clo_zero: got %0b, required 0", out_zero); end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(32'h0003_5A00, 1'b0);
    wait_done(lat);
    checks++; if (out_count !== 6'd14) begin errors++; $display("FAIL stall_count: got %0d, required 14", out_count); end
    checks++; if (out_norm !== 32'hD680_0000) begin errors++; $display("FAIL stall_norm: got %h, required d6800000", out_norm); end
    for (int unsigned i = 0; i < 10; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %0b, required 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %0b, required 0", i, in_ready); end
      checks++; if (out_count !== 6'd14 || out_norm !== 32'hD680_0000 || out_zero !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got count=%0d norm=%h zero=%0b, required 14 d6800000 0", i, out_count, out_norm, out_zero);
      end
    end
    // The next request is already presented during DONE. It must be accepted on the edge that follows the handshake.
    in_valid   = 1'b1;
    in_data    = 32'h0000_0001;
    count_ones = 1'b0;
    out_ready  = 1'b1;
    tick();
    out_ready  = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_hs: got %0b, required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_after_hs: got %0b, required 0", out_valid); end
    tick();
    in_valid   = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accepted: in_ready=%0b, required 0", in_ready); end
    in_data    = 32'hFFFF_FFFF;
    count_ones = 1'b1;
    wait_done(lat);
    checks++; if (lat != 5) begin errors++; $display("FAIL b2b_latency: got %0d, required 5", lat); end
    checks++; if (out_count !== 6'd31) begin errors++; $display("FAIL b2b_count: got %0d, required 31", out_count); end
    checks++; if (out_norm !== 32'h8000_0000) begin errors++; $display("FAIL b2b_norm: got %h, required 80000000", out_norm); end
    handshake();
  endtask

  task automatic test_reset_abort();
    int lat;
    start_op(32'h0000_0001, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %0b, required 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL abort_ready_in_reset: got %0b, required 0", in_ready); end
    checks++; if (out_count !== '0) begin errors++; $display("FAIL abort_count_cleared: got %0d, required 0", out_count); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready_release: got %0b, required 1", in_ready); end
    start_op(32'h0F00_0000, 1'b0);
    wait_done(lat);
    checks++; if (out_count !== 6'd4) begin errors++; $display("FAIL abort_next_count: got %0d, required 4", out_count); end
    checks++; if (out_norm !== 32'hF000_0000) begin errors++; $display("FAIL abort_next_norm: got %h, required f0000000", out_norm); end
    handshake();
  endtask

  task automatic test_msb_set();
    int lat;
    start_op(32'h8000_0000, 1'b0);
    wait_done(lat);
    checks++; if (lat != MSB_LAT) begin errors++; $display("FAIL msb_clz_latency: got %0d, required %0d", lat, MSB_LAT); end
    checks++; if (out_count !== 6'd0) begin errors++; $display("FAIL msb_clz_count: got %0d, required 0", out_count); end
    checks++; if (out_norm !== 32'h8000_0000) begin errors++; $display("FAIL msb_clz_norm: got %h, required 80000000", out_norm); end
    checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL msb_clz_zero: got %0b, required 0", out_zero); end
    handshake();
    start_op(32'h7FFF_FFFF, 1'b1);
    wait_done(lat);
    checks++; if (lat != MSB_LAT) begin errors++; $display("FAIL msb_clo_latency: got %0d, required %0d", lat, MSB_LAT); end
    checks++; if (out_count !== 6'd0) begin errors++; $display("FAIL msb_clo_count: got %0d, required 0", out_count); end
    checks++; if (out_norm !== 32'h7FFF_FFFF) begin errors++; $display("FAIL msb_clo_norm: got %h, required 7fffffff", out_norm); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_clz_basic();
    test_all_target();
    test_clo();
    test_back_to_back();
    test_reset_abort();
    test_msb_set();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
